// File: rtl/bin_to_bcd_8421_seq.sv
// bin_to_bcd_8421_seq: sequential double-dabble binary to packed 8421 BCD, one bit per clock.
// Define BCD_SAT_EN to add the overflow port and saturate the result to all nines.
module bin_to_bcd_8421_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef BCD_SAT_EN
  output logic                  overflow,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t               state;
  logic [BIN_W-1:0]     bin_sr;
  logic [4*DIGITS-1:0]  dig, adj, dig_nxt;
  logic [CW-1:0]        count;
  assign in_ready = (state == IDLE);
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = (dig[4*i+:4] >= 4'd5) ? dig[4*i+:4] + 4'd3 : dig[4*i+:4];
  end
`ifdef BCD_SAT_EN
  logic carry, ovf_flag, sat;
  assign {carry, dig_nxt} = {adj, bin_sr[BIN_W-1]};
  assign sat = ovf_flag | carry;
`else
  // The bit leaving the MS digit is worth 10^DIGITS and is simply dropped.
  assign dig_nxt = (4*DIGITS)'({adj, bin_sr[BIN_W-1]});
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      dig       <= '0;
      count     <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
`ifdef BCD_SAT_EN
      ovf_flag  <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bin_sr   <= bin_in;
          dig      <= '0;
          count    <= CW'(BIN_W);
`ifdef BCD_SAT_EN
          ovf_flag <= 1'b0;
`endif
          state    <= SHIFT;
        end
        SHIFT: begin
          bin_sr <= bin_sr << 1;
          dig    <= dig_nxt;
          count  <= count - CW'(1);
`ifdef BCD_SAT_EN
          ovf_flag <= sat;
`endif
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef BCD_SAT_EN
            bcd_out   <= sat ? {DIGITS{4'h9}} : dig_nxt;
            overflow  <= sat;
`else
            bcd_out   <= dig_nxt;
`endif
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
